// File: rtl/jogo_memoria_pkg.sv
// ---------------------------------------------------------------------------
// jogo_memoria_pkg
// Shared definitions for the parametrised memory game:
//   - estado_t   : FSM state encoding (codes are visible on db_estado)
//   - LFSR_SEED  : reset value of the sequence generator
//   - LFSR_TAPS  : feedback mask for taps 16/14/13/11 (bits 15/13/12/10)
//   - indice_para_onehot : button index -> one-hot vector
//   - eh_onehot          : true when exactly one bit is set
// ---------------------------------------------------------------------------
package jogo_memoria_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'h0,
        PREPARA     = 4'h1,
        GERA        = 4'h2,
        MOSTRA      = 4'h3,
        APAGA       = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        ULTIMA      = 4'h8,
        NOVA        = 4'h9,
        FIM_A       = 4'hA,
        FIM_T       = 4'hD,
        FIM_E       = 4'hE
    } estado_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int MAX_BOTOES = 8;

    // Widest supported button vector; callers cast down to N_BOTOES.
    function automatic logic [MAX_BOTOES-1:0] indice_para_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic logic eh_onehot(input logic [MAX_BOTOES-1:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/jogo_memoria_lfsr.sv
// ---------------------------------------------------------------------------
// jogo_memoria_lfsr
// 16-bit Fibonacci LFSR (taps 16/14/13/11) that advances every cycle and
// presents the next sequence element as a one-hot button vector.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high; loads LFSR_SEED
//   elemento out  one-hot of (lfsr[7:0] % N_BOTOES)
// ---------------------------------------------------------------------------
module jogo_memoria_lfsr
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic [N_BOTOES-1:0] elemento
);

    logic [15:0] lfsr;
    logic [2:0]  idx;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign idx      = 3'(lfsr[7:0] % 8'(N_BOTOES));
    assign elemento = N_BOTOES'(indice_para_onehot(idx));

endmodule

// File: rtl/jogo_memoria_param.sv
// ---------------------------------------------------------------------------
// jogo_memoria_param
// Parametrised memory-game engine. Each round one element is appended to the
// sequence (from the LFSR, or from the player in modo=1), the sequence is
// played back on the LEDs, and the player's presses are checked in order.
//
// Configuration macro: JOGO_TIMEOUT_EN
//   defined   -> per-press timeout counter; ESPERA/NOVA can end in FIM_T
//   undefined -> ESPERA/NOVA wait forever; timeout tied low
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   iniciar    in   start/restart (honoured only in IDLE and FIM_*)
//   modo       in   0 = LFSR sequence, 1 = player-built; sampled with iniciar
//   botoes     in   synchronised buttons
//   leds       out  LED drive (playback in MOSTRA, mirror of botoes in ESPERA)
//   pronto     out  game over (FIM_A / FIM_E / FIM_T)
//   ganhou     out  won (FIM_A)
//   perdeu     out  lost (FIM_E / FIM_T)
//   timeout    out  lost by timeout (FIM_T)
//   db_estado  out  state code
//   db_rodada  out  current round, 1-based
//   db_jogada  out  position being shown/checked, 0-based
// ---------------------------------------------------------------------------
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int T_MOSTRA       = 25_000_000,
    parameter int TIMEOUT_CICLOS = 150_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [4:0]          db_rodada,
    output logic [4:0]          db_jogada
);

    localparam int W_IDX = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
    localparam int W_ROD = $clog2(MAX_RODADAS + 1);
    localparam int W_MOS = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;

    estado_t             estado, prox_estado;
    logic [W_ROD-1:0]    rodada;
    logic [W_IDX-1:0]    jogada;
    logic                modo_r;
    logic [N_BOTOES-1:0] captura;
    logic                prev_any;
    logic [W_MOS-1:0]    cnt_mostra;

    logic [N_BOTOES-1:0] mem [MAX_RODADAS];
    logic [N_BOTOES-1:0] mem_atual;
    logic [N_BOTOES-1:0] elemento;

    logic                press;
    logic                botoes_onehot;
    logic                captura_ok;
    logic                cnt_fim;
    logic                is_last;
    logic                expirou;
    logic [W_ROD-1:0]    limite;
    logic [W_ROD-1:0]    ultimo_idx;

    logic                mem_we;
    logic [W_IDX-1:0]    wr_addr;
    logic [N_BOTOES-1:0] mem_wdata;

    // ----------------------------------------------------------------------
    // Sequence generator
    // ----------------------------------------------------------------------
    jogo_memoria_lfsr #(
        .N_BOTOES (N_BOTOES)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .elemento (elemento)
    );

    // ----------------------------------------------------------------------
    // Derived conditions
    // ----------------------------------------------------------------------
    // A press is the rising edge of "any button held"; holding a button
    // therefore counts once.
    assign press         = (|botoes) & ~prev_any;
    assign botoes_onehot = eh_onehot(8'(botoes));
    assign mem_atual     = mem[jogada];
    assign captura_ok    = eh_onehot(8'(captura)) && (captura == mem_atual);
    assign cnt_fim       = (cnt_mostra == W_MOS'(T_MOSTRA - 1));

    // In player-built mode the newest element is not yet in memory when the
    // round is played back, so one fewer entry is shown and repeated.
    assign limite     = modo_r ? (rodada - W_ROD'(1)) : rodada;
    assign ultimo_idx = limite - W_ROD'(1);
    assign is_last    = (W_ROD'(jogada) == ultimo_idx);
    assign wr_addr    = W_IDX'(rodada - W_ROD'(1));

    // ----------------------------------------------------------------------
    // Per-press timeout
    // ----------------------------------------------------------------------
`ifdef JOGO_TIMEOUT_EN
    localparam int W_TMO = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [W_TMO-1:0] timer;

    // Any state other than ESPERA/NOVA holds the timer at zero, so it is
    // clear on every entry into a waiting state.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (estado == ESPERA || estado == NOVA) begin
            timer <= timer + W_TMO'(1);
        end else begin
            timer <= '0;
        end
    end

    assign expirou = (estado == ESPERA || estado == NOVA) &&
                     (timer == W_TMO'(TIMEOUT_CICLOS - 1));
    assign timeout = (estado == FIM_T);
`else
    assign expirou = 1'b0;
    assign timeout = 1'b0;
`endif

    // ----------------------------------------------------------------------
    // State register
    // ----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    // ----------------------------------------------------------------------
    // Next-state logic
    // ----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prox_estado = estado;
        unique case (estado)
            IDLE, FIM_A, FIM_E, FIM_T: begin
                if (iniciar) prox_estado = PREPARA;
            end
            PREPARA: prox_estado = GERA;
            GERA: begin
                if (modo_r && rodada == W_ROD'(1)) prox_estado = NOVA;
                else                               prox_estado = MOSTRA;
            end
            MOSTRA: begin
                if (cnt_fim) prox_estado = APAGA;
            end
            APAGA: begin
                if (cnt_fim) begin
                    if (limite == '0)   prox_estado = NOVA;
                    else if (!is_last)  prox_estado = MOSTRA;
                    else                prox_estado = ESPERA;
                end
            end
            ESPERA: begin
                // A press in the expiry cycle takes priority.
                if (press)        prox_estado = COMPARA;
                else if (expirou) prox_estado = FIM_T;
            end
            COMPARA: begin
                if (!captura_ok)  prox_estado = FIM_E;
                else if (is_last) prox_estado = modo_r ? NOVA : ULTIMA;
                else              prox_estado = PROX_JOGADA;
            end
            PROX_JOGADA: prox_estado = ESPERA;
            NOVA: begin
                if (press)        prox_estado = botoes_onehot ? ULTIMA : FIM_E;
                else if (expirou) prox_estado = FIM_T;
            end
            ULTIMA: begin
                if (rodada == W_ROD'(MAX_RODADAS)) prox_estado = FIM_A;
                else                               prox_estado = GERA;
            end
            default: prox_estado = IDLE;
        endcase
    end

    // ----------------------------------------------------------------------
    // Datapath registers
    // ----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rodada     <= '0;
            jogada     <= '0;
            modo_r     <= 1'b0;
            captura    <= '0;
            prev_any   <= 1'b0;
            cnt_mostra <= '0;
        end else begin
            prev_any <= |botoes;

            if (estado == MOSTRA || estado == APAGA) begin
                cnt_mostra <= cnt_fim ? '0 : cnt_mostra + W_MOS'(1);
            end else begin
                cnt_mostra <= '0;
            end

            unique case (estado)
                IDLE, FIM_A, FIM_E, FIM_T: begin
                    if (iniciar) modo_r <= modo;
                end
                PREPARA: begin
                    rodada <= W_ROD'(1);
                    jogada <= '0;
                end
                GERA: jogada <= '0;
                APAGA: begin
                    if (cnt_fim) begin
                        if (limite != '0 && !is_last) jogada <= jogada + W_IDX'(1);
                        else                          jogada <= '0;
                    end
                end
                ESPERA: begin
                    if (press) captura <= botoes;
                end
                PROX_JOGADA: jogada <= jogada + W_IDX'(1);
                ULTIMA: begin
                    if (rodada != W_ROD'(MAX_RODADAS)) rodada <= rodada + W_ROD'(1);
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------------------
    // Sequence memory
    // ----------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = elemento;
        if (estado == GERA && !modo_r) begin
            mem_we = 1'b1;
        end else if (estado == NOVA && press && botoes_onehot) begin
            mem_we    = 1'b1;
            mem_wdata = botoes;
        end
    end

    // NOTE: the sequence memory is deliberately left out of reset; every
    // entry is written before it is read, and a reset-free array maps onto
    // plain RAM/LUT storage.
    always_ff @(posedge clock) begin
        if (mem_we) mem[wr_addr] <= mem_wdata;
    end

    // ----------------------------------------------------------------------
    // Outputs
    // ----------------------------------------------------------------------
    always_comb begin
        leds = '0;
        if (estado == MOSTRA)      leds = mem_atual;
        else if (estado == ESPERA) leds = botoes;
    end

    assign pronto    = (estado == FIM_A) || (estado == FIM_E) || (estado == FIM_T);
    assign ganhou    = (estado == FIM_A);
    assign perdeu    = (estado == FIM_E) || (estado == FIM_T);
    assign db_estado = estado;
    assign db_rodada = 5'(rodada);
    assign db_jogada = 5'(jogada);

endmodule
